registro_llamadas: RTL and testbench

- Call-register stage directly upstream of the elevator floor state machine.
- Latches cabin and hall button presses into a pending-request vector and clears requests once they are served.
- Runs a direction state machine (IDLE/UP/DOWN) and drives the 4-bit request code `memoria` (0..10) that the floor FSM consumes.
- Four floors; floors are encoded 0..3 internally.

---
 rtl/registro_llamadas.sv | 241 ++++++++++++++++++++++++
 tb/tb_registro_llamadas.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/registro_llamadas.sv
// ============================================================================
// Module      : registro_llamadas
// Description : Elevator call register. Latches cabin and hall button presses
//               into a pending-request vector, clears the bits of a floor when
//               it is served, and runs an IDLE/UP/DOWN direction FSM that
//               drives the request code `memoria` consumed by the floor FSM.
//               Optional macro REG_LLAMADAS_ANTIRREBOTE_EN adds a 2-flop
//               synchronizer and debounce counter on every button input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registro_llamadas #(
    parameter int N_PISOS            = 4,
    parameter int ANTIRREBOTE_CICLOS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] btn_cabina,
    input  logic [2:0] btn_subir,
    input  logic [2:0] btn_bajar,
    input  logic [1:0] piso,
    input  logic       puertas,
    output logic [3:0] memoria,
    output logic [9:0] pendientes,
    output logic [1:0] direccion,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // Parameters outside the supported range abort elaboration.
    if (N_PISOS != 4 || ANTIRREBOTE_CICLOS < 2 || ANTIRREBOTE_CICLOS > 255) begin : g_param_check
        $error("registro_llamadas: unsupported parameter value");
    end

    // Button vector in request-code order: bit k-1 holds code k.
    logic [9:0] w_raw;
    logic [9:0] w_lvl;
    logic [9:0] r_prev;
    logic [9:0] w_edge;
    logic [9:0] w_clr;
    logic [9:0] r_pend;

    assign w_raw = {btn_bajar[2], btn_subir[2], btn_bajar[1], btn_subir[1],
                    btn_bajar[0], btn_subir[0], btn_cabina};

`ifdef REG_LLAMADAS_ANTIRREBOTE_EN
    for (genvar i = 0; i < 10; i++) begin : g_antirrebote
        logic       r_s1;
        logic       r_s2;
        logic       r_db;
        logic [7:0] r_cnt;

        // Synchronize, then accept a new level only after enough equal samples.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_cnt <= 8'd0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_db) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == 8'(ANTIRREBOTE_CICLOS - 1)) begin
                    r_db  <= r_s2;
                    r_cnt <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end

        assign w_lvl[i] = r_db;
    end
`else
    assign w_lvl = w_raw;
`endif

    assign w_edge = w_lvl & ~r_prev;

    // Bits belonging to the floor the doors are open at.
    always_comb begin
        w_clr = 10'd0;
        if (puertas) begin
            case (piso)
                2'd0:    w_clr = 10'b00_0001_0001;
                2'd1:    w_clr = 10'b00_0110_0010;
                2'd2:    w_clr = 10'b01_1000_0100;
                default: w_clr = 10'b10_0000_1000;
            endcase
        end
    end

    // Button history and pending vector; clear wins over a same-cycle press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 10'd0;
            r_pend <= 10'd0;
        end else begin
            r_prev <= w_lvl;
            r_pend <= (r_pend | w_edge) & ~w_clr;
        end
    end

    logic [N_PISOS-1:0] w_req;
    logic [1:0]         w_near, w_up_t, w_dn_t, w_tgt;
    logic               w_near_ok, w_up_ok, w_dn_ok, w_tgt_ok;
    state_t             r_state, w_state_nx;
    logic [3:0]         r_mem, w_mem_nx;

    assign w_req[0] = r_pend[0] | r_pend[4];
    assign w_req[1] = r_pend[1] | r_pend[5] | r_pend[6];
    assign w_req[2] = r_pend[2] | r_pend[7] | r_pend[8];
    assign w_req[3] = r_pend[3] | r_pend[9];

    // Candidate targets: nearest (tie low), lowest at/above, highest at/below.
    always_comb begin
        w_near    = 2'd0;
        w_near_ok = 1'b0;
        w_up_t    = 2'd0;
        w_up_ok   = 1'b0;
        w_dn_t    = 2'd0;
        w_dn_ok   = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (!w_near_ok) begin
                if ((int'(piso) - d >= 0) && w_req[2'(int'(piso) - d)]) begin
                    w_near    = 2'(int'(piso) - d);
                    w_near_ok = 1'b1;
                end else if ((int'(piso) + d <= 3) && w_req[2'(int'(piso) + d)]) begin
                    w_near    = 2'(int'(piso) + d);
                    w_near_ok = 1'b1;
                end
            end
        end
        for (int f = 3; f >= 0; f--) begin
            if (f >= int'(piso) && w_req[2'(f)]) begin
                w_up_t  = 2'(f);
                w_up_ok = 1'b1;
            end
        end
        for (int f = 0; f < 4; f++) begin
            if (f <= int'(piso) && w_req[2'(f)]) begin
                w_dn_t  = 2'(f);
                w_dn_ok = 1'b1;
            end
        end
    end

    // Request code of a floor: cabin first, then hall code matching direction.
    function automatic logic [3:0] f_code(input logic [1:0] f, input logic dn,
                                          input logic [9:0] p);
        logic [3:0] v_code;
        v_code = 4'd0;
        case (f)
            2'd0: v_code = p[0] ? 4'd1 : (p[4] ? 4'd5 : 4'd0);
            2'd1: begin
                if (p[1])    v_code = 4'd2;
                else if (dn) v_code = p[5] ? 4'd6 : (p[6] ? 4'd7 : 4'd0);
                else         v_code = p[6] ? 4'd7 : (p[5] ? 4'd6 : 4'd0);
            end
            2'd2: begin
                if (p[2])    v_code = 4'd3;
                else if (dn) v_code = p[7] ? 4'd8 : (p[8] ? 4'd9 : 4'd0);
                else         v_code = p[8] ? 4'd9 : (p[7] ? 4'd8 : 4'd0);
            end
            default: v_code = p[3] ? 4'd4 : (p[9] ? 4'd10 : 4'd0);
        endcase
        return v_code;
    endfunction

    // Direction FSM next state and the target code it will publish.
    always_comb begin
        w_state_nx = r_state;
        w_tgt      = 2'd0;
        w_tgt_ok   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_near_ok) begin
                    w_tgt    = w_near;
                    w_tgt_ok = 1'b1;
                    if (w_near > piso)      w_state_nx = ST_UP;
                    else if (w_near < piso) w_state_nx = ST_DOWN;
                    else                    w_state_nx = ST_IDLE;
                end
            end
            ST_UP: begin
                if (w_up_ok) begin
                    w_tgt    = w_up_t;
                    w_tgt_ok = 1'b1;
                end else if (w_dn_ok) begin
                    w_state_nx = ST_DOWN;
                    w_tgt      = w_dn_t;
                    w_tgt_ok   = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DOWN: begin
                if (w_dn_ok) begin
                    w_tgt    = w_dn_t;
                    w_tgt_ok = 1'b1;
                end else if (w_up_ok) begin
                    w_state_nx = ST_UP;
                    w_tgt      = w_up_t;
                    w_tgt_ok   = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        w_mem_nx = w_tgt_ok ? f_code(w_tgt, w_state_nx == ST_DOWN, r_pend) : 4'd0;
    end

    // Direction and request code advance together, only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mem   <= 4'd0;
        end else if (en) begin
            r_state <= w_state_nx;
            r_mem   <= w_mem_nx;
        end
    end

    assign memoria    = r_mem;
    assign pendientes = r_pend;
    assign direccion  = r_state;
    assign ocupado    = |r_pend;

endmodule

`default_nettype wire

// File: tb/tb_registro_llamadas.sv
// ============================================================================
// Module      : tb_registro_llamadas
// Description : Directed self-checking bench for registro_llamadas.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registro_llamadas;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] btn_cabina = 4'd0;
    logic [2:0] btn_subir = 3'd0;
    logic [2:0] btn_bajar = 3'd0;
    logic [1:0] piso = 2'd0;
    logic       puertas = 1'b0;
    logic [3:0] memoria;
    logic [9:0] pendientes;
    logic [1:0] direccion;
    logic       ocupado;

    int n_vec = 0;
    int n_bad = 0;

    registro_llamadas #(.N_PISOS(4), .ANTIRREBOTE_CICLOS(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_cabina (btn_cabina),
        .btn_subir  (btn_subir),
        .btn_bajar  (btn_bajar),
        .piso       (piso),
        .puertas    (puertas),
        .memoria    (memoria),
        .pendientes (pendientes),
        .direccion  (direccion),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle press of any combination of buttons.
    task automatic press(input logic [3:0] cab, input logic [2:0] sub, input logic [2:0] baj);
        btn_cabina = cab;
        btn_subir  = sub;
        btn_bajar  = baj;
        tick();
        btn_cabina = 4'd0;
        btn_subir  = 3'd0;
        btn_bajar  = 3'd0;
    endtask

    initial begin
        #2 rst = 1'b0;
        #2;
        chk("rst_pend", 32'(pendientes), 32'h0);
        chk("rst_mem",  32'(memoria),    32'd0);
        chk("rst_dir",  32'(direccion),  32'd0);
        chk("rst_ocu",  32'(ocupado),    32'd0);
        tick();
        rst = 1'b1;
        tick();

`ifdef REG_LLAMADAS_ANTIRREBOTE_EN
        piso = 2'd2;
        btn_cabina = 4'b0001;
        repeat (5) tick();
        btn_cabina = 4'd0;
        repeat (15) tick();
        chk("db_short_pulse", 32'(pendientes), 32'h0);
        btn_cabina = 4'b0001;
        repeat (10) tick();
        chk("db_before_lat", 32'(pendientes), 32'h0);
        tick();
        chk("db_after_lat", 32'(pendientes), 32'h001);
        tick();
        btn_cabina = 4'd0;
        repeat (15) tick();
        chk("db_kept", 32'(pendientes), 32'h001);
`else
        // Cabin call to floor 2 from floor 0.
        press(4'b0100, 3'd0, 3'd0);
        chk("t1_pend", 32'(pendientes), 32'h004);
        chk("t1_ocu",  32'(ocupado),    32'd1);
        chk("t1_mem_lat", 32'(memoria), 32'd0);
        tick();
        chk("t1_mem", 32'(memoria),   32'd3);
        chk("t1_dir", 32'(direccion), 32'd1);

        // Floor 2 down call joins, then floor 2 is served.
        press(4'd0, 3'd0, 3'b010);
        chk("t2_pend", 32'(pendientes), 32'h084);
        piso = 2'd2;
        puertas = 1'b1;
        tick();
        chk("t2_clear", 32'(pendientes), 32'h0);
        chk("t2_ocu",   32'(ocupado),    32'd0);
        chk("t2_mem_hold", 32'(memoria), 32'd3);
        tick();
        chk("t2_mem", 32'(memoria),   32'd0);
        chk("t2_dir", 32'(direccion), 32'd0);

        // Press at served floor is dropped, other floor latches.
        press(4'b0110, 3'd0, 3'd0);
        chk("drop_pend", 32'(pendientes), 32'h002);
        piso = 2'd1;
        tick();
        chk("drop_clear", 32'(pendientes), 32'h0);
        chk("same_floor_mem", 32'(memoria),   32'd2);
        chk("same_floor_dir", 32'(direccion), 32'd0);
        puertas = 1'b0;
        tick();
        chk("same_floor_idle", 32'(memoria), 32'd0);

        // Held button sets once and does not re-set after being served.
        btn_cabina = 4'b1000;
        tick();
        tick();
        chk("held_pend", 32'(pendientes), 32'h008);
        piso = 2'd3;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        tick();
        chk("held_no_reset", 32'(pendientes), 32'h0);
        btn_cabina = 4'd0;
        tick();
        chk("held_idle_dir", 32'(direccion), 32'd0);

        // UP from floor 1 with floors 0 and 3 pending, then reverse.
        piso = 2'd1;
        press(4'b1000, 3'd0, 3'd0);
        tick();
        press(4'b0001, 3'd0, 3'd0);
        tick();
        chk("t3_pend", 32'(pendientes), 32'h009);
        chk("t3_mem",  32'(memoria),    32'd4);
        chk("t3_dir",  32'(direccion),  32'd1);
        piso = 2'd3;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        tick();
        chk("t3_rev_mem", 32'(memoria),   32'd1);
        chk("t3_rev_dir", 32'(direccion), 32'd2);
        piso = 2'd0;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        tick();
        chk("t3_idle", 32'(direccion), 32'd0);

        // Tie between floor 0 up and floor 2 down from floor 1.
        piso = 2'd1;
        press(4'd0, 3'b001, 3'b010);
        chk("t4_pend", 32'(pendientes), 32'h090);
        tick();
        chk("t4_mem", 32'(memoria),   32'd5);
        chk("t4_dir", 32'(direccion), 32'd2);
        piso = 2'd0;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        tick();
        chk("t4_up_mem", 32'(memoria),   32'd8);
        chk("t4_up_dir", 32'(direccion), 32'd1);
        piso = 2'd2;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        tick();
        chk("t4_idle", 32'(memoria), 32'd0);

        // Disabled FSM holds while latching continues.
        en = 1'b0;
        press(4'd0, 3'd0, 3'b100);
        chk("t5_pend", 32'(pendientes), 32'h200);
        tick();
        chk("t5_mem_hold", 32'(memoria),   32'd0);
        chk("t5_dir_hold", 32'(direccion), 32'd0);
        en = 1'b1;
        tick();
        chk("t5_mem", 32'(memoria),   32'd10);
        chk("t5_dir", 32'(direccion), 32'd1);
        en = 1'b0;
        piso = 2'd3;
        puertas = 1'b1;
        tick();
        puertas = 1'b0;
        chk("t5_clear_dis", 32'(pendientes), 32'h0);
        chk("t5_mem_keep",  32'(memoria),    32'd10);
        en = 1'b1;

        // Asynchronous reset mid-operation.
        press(4'b0001, 3'd0, 3'd0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_pend", 32'(pendientes), 32'h0);
        chk("arst_mem",  32'(memoria),    32'd0);
        chk("arst_dir",  32'(direccion),  32'd0);
        tick();
        rst = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
